pbit_network_sampler: RTL and testbench

- Generalised invertible p-bit Ising network of N_PBITS nodes.
- Coupling matrix J and bias H are parameters; each bit is clamped or free at runtime.
- Round-robin sequential update with one shared LFSR; a start/done-handshaked sampler runs burn-in sweeps, then accumulates per-bit "ones" counts over n_samples sweeps.
- Successor to the fixed 3-bit invertible gates; the building block for wider invertible adders and multipliers.

---
 rtl/pbit_pkg.sv | 22 ++
 rtl/pbit_lfsr32.sv | 30 +++
 rtl/pbit_network_sampler.sv | 196 +++++++++++++++++++
 tb/tb_pbit_network_sampler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pbit_pkg.sv
// pbit_pkg: shared state type and constants for the p-bit network sampler
// and its LFSR.
package pbit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURN,
        SAMPLE,
        DONE
    } pbit_state_t;

    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    localparam int unsigned COUNT_W = 16;
    localparam int unsigned BETA_W  = 4;

    // Bit positions inside each 2-bit {en,val} clamp field
    localparam int unsigned CLAMP_EN  = 1;
    localparam int unsigned CLAMP_VAL = 0;

endpackage

// File: rtl/pbit_lfsr32.sv
// pbit_lfsr32: 32-bit Galois LFSR with enable. A zero seed is replaced by 1
// so the register can never lock up. Exposes the low OUT_W bits.
module pbit_lfsr32
    import pbit_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'h45bc3a97,
    parameter int unsigned OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [OUT_W-1:0] rnd
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] state;

    // Shift right one step per enabled cycle, folding the taps in on a 1 out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_EFF;
        end else if (en) begin
            state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'd0);
        end
    end

    assign rnd = state[OUT_W-1:0];

endmodule

// File: rtl/pbit_network_sampler.sv
// pbit_network_sampler: invertible p-bit Ising network with round-robin
// single-node updates, burn-in sweeps and per-bit "ones" counting.
// Optional macro PBIT_ANNEAL_EN ramps beta during burn-in.
module pbit_network_sampler
    import pbit_pkg::*;
#(
    parameter int unsigned N_PBITS          = 3,
    parameter int unsigned WEIGHT_PRECISION = 6,
    parameter logic [N_PBITS*N_PBITS*WEIGHT_PRECISION-1:0] J_FLAT = '0,
    parameter logic [N_PBITS*WEIGHT_PRECISION-1:0]         H_FLAT = '0,
    parameter int unsigned RAND_W           = 8,
    parameter logic [31:0] SEED             = 32'h45bc3a97,
    parameter int unsigned ANNEAL_STEP      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [BETA_W-1:0]            i0,
    input  logic [COUNT_W-1:0]           burn_sweeps,
    input  logic [COUNT_W-1:0]           n_samples,
    input  logic [2*N_PBITS-1:0]         clamp,
    output logic                         busy,
    output logic                         done,
    output logic [N_PBITS-1:0]           p_bits,
    output logic [COUNT_W*N_PBITS-1:0]   counts
);

    localparam int unsigned PTR_W   = $clog2(N_PBITS);
    localparam int unsigned FIELD_W = WEIGHT_PRECISION + $clog2(N_PBITS) + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_PBITS - 1);
    localparam int SAT_HI = (1 << (RAND_W - 1)) - 1;
    localparam int SAT_LO = -(1 << (RAND_W - 1));

    if (N_PBITS < 2 || N_PBITS > 16 || ANNEAL_STEP < 1) begin : g_param_check
        $error("pbit_network_sampler: N_PBITS or ANNEAL_STEP out of range");
    end

    pbit_state_t state, state_nxt;

    logic [PTR_W-1:0]                ptr;
    logic [COUNT_W-1:0]              sweep_cnt, burn_lat, samp_lat;
    logic [BETA_W-1:0]               beta_lat, beta_eff;
    logic [RAND_W-1:0]               rnd;
    logic                            start_ok, sweep_end, phase_last;
    logic [N_PBITS-1:0]              cl_en, cl_val, p_nxt;
    logic signed [WEIGHT_PRECISION-1:0] w;
    logic signed [FIELD_W-1:0]       field;
    int                              prod;
    logic signed [RAND_W-1:0]        ie, r;
    logic                            new_bit;

    assign start_ok   = start && (state == IDLE || state == DONE);
    assign sweep_end  = busy && (ptr == PTR_LAST);
    assign phase_last = (state == BURN) ? (sweep_cnt == burn_lat - 16'd1)
                                        : (sweep_cnt == samp_lat - 16'd1);

    pbit_lfsr32 #(
        .SEED  (SEED),
        .OUT_W (RAND_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (reset),
        .en    (busy),
        .rnd   (rnd)
    );

`ifdef PBIT_ANNEAL_EN
    logic [BETA_W-1:0]  anneal_beta;
    logic [COUNT_W-1:0] step_cnt;

    // Burn-in beta ramp: starts at 1, +1 every ANNEAL_STEP sweeps, capped at i0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anneal_beta <= '0;
            step_cnt    <= '0;
        end else if (start_ok) begin
            anneal_beta <= (i0 != '0) ? BETA_W'(1) : '0;
            step_cnt    <= '0;
        end else if (state == BURN && sweep_end) begin
            if (step_cnt == COUNT_W'(ANNEAL_STEP - 1)) begin
                step_cnt <= '0;
                if (anneal_beta < beta_lat) anneal_beta <= anneal_beta + 1'b1;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    assign beta_eff = (state == BURN) ? anneal_beta : beta_lat;
`else
    assign beta_eff = beta_lat;
`endif

    // Split the packed {en,val} clamp pairs into per-bit vectors
    always_comb begin
        cl_en  = '0;
        cl_val = '0;
        for (int unsigned k = 0; k < N_PBITS; k++) begin
            cl_en[k]  = clamp[2*k + CLAMP_EN];
            cl_val[k] = clamp[2*k + CLAMP_VAL];
        end
    end

    // Local field of the selected node, scaled by beta, saturated and compared
    always_comb begin
        w     = H_FLAT[32'(ptr)*WEIGHT_PRECISION +: WEIGHT_PRECISION];
        field = FIELD_W'(w);
        for (int unsigned j = 0; j < N_PBITS; j++) begin
            if (j != 32'(ptr)) begin
                w     = J_FLAT[(32'(ptr)*N_PBITS + j)*WEIGHT_PRECISION +: WEIGHT_PRECISION];
                field = p_bits[j] ? field + FIELD_W'(w) : field - FIELD_W'(w);
            end
        end
        prod = int'(field) * int'({1'b0, beta_eff});
        if (prod > SAT_HI)      ie = RAND_W'(SAT_HI);
        else if (prod < SAT_LO) ie = RAND_W'(SAT_LO);
        else                    ie = RAND_W'(prod);
        r       = rnd;
        new_bit = (ie > r);
    end

    // Spin vector after this cycle's single-node update
    always_comb begin
        p_nxt      = p_bits;
        p_nxt[ptr] = cl_en[ptr] ? cl_val[ptr] : new_bit;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: phases advance on the update edge of the last node
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (burn_sweeps != '0)    state_nxt = BURN;
                    else if (n_samples != '0) state_nxt = SAMPLE;
                    else                      state_nxt = DONE;
                end
            end
            BURN: begin
                if (sweep_end && phase_last) state_nxt = (samp_lat != '0) ? SAMPLE : DONE;
            end
            SAMPLE: begin
                if (sweep_end && phase_last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == BURN) || (state == SAMPLE);
        done = (state == DONE);
    end

    // Datapath: run latching, node pointer, sweep counting, spins and counts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            sweep_cnt <= '0;
            burn_lat  <= '0;
            samp_lat  <= '0;
            beta_lat  <= '0;
            p_bits    <= '0;
            counts    <= '0;
        end else if (start_ok) begin
            ptr       <= '0;
            sweep_cnt <= '0;
            burn_lat  <= burn_sweeps;
            samp_lat  <= n_samples;
            beta_lat  <= i0;
            p_bits    <= (p_bits & ~cl_en) | (cl_val & cl_en);
            counts    <= '0;
        end else if (busy) begin
            p_bits <= p_nxt;
            if (ptr == PTR_LAST) begin
                ptr       <= '0;
                sweep_cnt <= phase_last ? '0 : sweep_cnt + 1'b1;
                if (state == SAMPLE) begin
                    for (int unsigned k = 0; k < N_PBITS; k++) begin
                        counts[k*COUNT_W +: COUNT_W] <=
                            counts[k*COUNT_W +: COUNT_W] + COUNT_W'(p_nxt[k]);
                    end
                end
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pbit_network_sampler.sv
// tb_pbit_network_sampler: drives two 3-bit networks (AND-gate weights and
// all-zero weights with a zero seed) with identical stimulus and compares
// each run against a sweep-level behavioural model plus fixed expectations.
module tb_pbit_network_sampler;

    // J[i][j] at entry i*3+j, MSB entry first: J22 J21 J20 J12 J11 J10 J02 J01 J00
    localparam logic [53:0] AND_J = {6'h00, 6'h08, 6'h08,
                                     6'h08, 6'h00, 6'h3c,
                                     6'h08, 6'h3c, 6'h00};
    // H2 (y) = -8, H1 (b) = 4, H0 (a) = 4
    localparam logic [17:0] AND_H = {6'h38, 6'h04, 6'h04};
    localparam logic [31:0] SEED_A = 32'h45bc3a97;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  i0;
    logic [15:0] burn_sweeps, n_samples;
    logic [5:0]  clamp;
    logic        busy_a, done_a, busy_f, done_f;
    logic [2:0]  pb_a, pb_f;
    logic [47:0] cnt_a, cnt_f;

    always #5 clk = ~clk;

    pbit_network_sampler #(
        .N_PBITS(3), .WEIGHT_PRECISION(6), .J_FLAT(AND_J), .H_FLAT(AND_H),
        .RAND_W(8), .SEED(SEED_A), .ANNEAL_STEP(4)
    ) u_and (
        .clk(clk), .reset(rst_n), .start(start), .i0(i0),
        .burn_sweeps(burn_sweeps), .n_samples(n_samples), .clamp(clamp),
        .busy(busy_a), .done(done_a), .p_bits(pb_a), .counts(cnt_a)
    );

    pbit_network_sampler #(
        .N_PBITS(3), .WEIGHT_PRECISION(6), .J_FLAT(54'd0), .H_FLAT(18'd0),
        .RAND_W(8), .SEED(32'h0), .ANNEAL_STEP(4)
    ) u_flat (
        .clk(clk), .reset(rst_n), .start(start), .i0(i0),
        .burn_sweeps(burn_sweeps), .n_samples(n_samples), .clamp(clamp),
        .busy(busy_f), .done(done_f), .p_bits(pb_f), .counts(cnt_f)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int wj_a[3][3] = '{'{0, -4, 8}, '{-4, 0, 8}, '{8, 8, 0}};
    int wh_a[3]    = '{4, 4, -8};
    int wj_z[3][3] = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    int wh_z[3]    = '{0, 0, 0};

    logic [2:0]  pb_ma, pb_mf;
    logic [31:0] lf_ma, lf_mf;

    typedef struct {
        int         beta;
        int         burn;
        int         ns;
        logic [5:0] cl;
        int         c0, c1, c2;
        logic [2:0] pb;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Whole-run model: sweeps of in-place single-node Gibbs updates
    task automatic model_run(input int wj[3][3], input int wh[3], input int beta,
                             input int burn, input int ns, input logic [5:0] cl,
                             inout logic [2:0] pb, inout logic [31:0] lf,
                             output int cnt[3]);
        int  fld, ie, r;
        byte rb;
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0;
            if (cl[2*k+1]) pb[k] = cl[2*k];
        end
        for (int s = 0; s < burn + ns; s++) begin
            for (int k = 0; k < 3; k++) begin
                if (cl[2*k+1]) begin
                    pb[k] = cl[2*k];
                end else begin
                    fld = wh[k];
                    for (int j = 0; j < 3; j++)
                        if (j != k) fld += pb[j] ? wj[k][j] : -wj[k][j];
                    ie = fld * beta;
                    if (ie > 127)  ie = 127;
                    if (ie < -128) ie = -128;
                    rb = lf[7:0];
                    r  = rb;
                    pb[k] = (ie > r);
                end
                lf = {1'b0, lf[31:1]} ^ (lf[0] ? 32'h80200003 : 32'h0);
            end
            if (s >= burn)
                for (int k = 0; k < 3; k++) cnt[k] += int'(pb[k]);
        end
    endtask

    // One start/done transaction; poke_at >= 0 pulses start (with altered inputs) mid-run
    task automatic do_run(input string tag, input int beta, input int burn, input int ns,
                          input logic [5:0] cl, input int poke_at);
        int ea[3], ef[3];
        int busy_cnt, waited, exp_busy;
        model_run(wj_a, wh_a, beta, burn, ns, cl, pb_ma, lf_ma, ea);
        model_run(wj_z, wh_z, beta, burn, ns, cl, pb_mf, lf_mf, ef);
        exp_busy = (burn + ns) * 3;
        @(negedge clk);
        i0 = 4'(beta); burn_sweeps = 16'(burn); n_samples = 16'(ns); clamp = cl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        waited   = 0;
        while (!done_a && waited < exp_busy + 20) begin
            if (busy_a) busy_cnt++;
            if (waited == poke_at) begin
                start = 1'b1; n_samples = 16'd2; burn_sweeps = 16'd0; i0 = 4'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        check($sformatf("%s_done_and", tag), int'(done_a), 1);
        check($sformatf("%s_done_flat", tag), int'(done_f), 1);
        check($sformatf("%s_busy_cycles", tag), busy_cnt, exp_busy);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_cnt_and[%0d]", tag, k), int'(cnt_a[16*k +: 16]), ea[k]);
            check($sformatf("%s_cnt_flat[%0d]", tag, k), int'(cnt_f[16*k +: 16]), ef[k]);
        end
        check($sformatf("%s_pbits_and", tag), int'(pb_a), int'(pb_ma));
        check($sformatf("%s_pbits_flat", tag), int'(pb_f), int'(pb_mf));
    endtask

    initial begin
        vecs[0] = '{2, 2, 5, 6'b11_10_11, 5, 0, 5, 3'b101};
        vecs[1] = '{2, 0, 0, 6'b11_10_11, 0, 0, 0, 3'b101};
        vecs[2] = '{4, 0, 3, 6'b10_11_10, 0, 3, 0, 3'b010};
        vecs[3] = '{1, 1, 0, 6'b11_11_11, 0, 0, 0, 3'b111};
        vecs[4] = '{9, 3, 7, 6'b10_11_11, 7, 7, 0, 3'b011};

        rst_n = 1'b0; start = 1'b0; i0 = '0;
        burn_sweeps = '0; n_samples = '0; clamp = '0;
        pb_ma = '0; pb_mf = '0; lf_ma = SEED_A; lf_mf = 32'd1;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy_a | busy_f), 0);
        check("reset_done", int'(done_a | done_f), 0);
        check("reset_pbits", int'(pb_a | pb_f), 0);
        check("reset_counts", int'((cnt_a | cnt_f) != 48'd0), 0);
        rst_n = 1'b1;

        // Fully clamped runs: counts are fixed by the clamp pattern alone
        for (int v = 0; v < 5; v++) begin
            do_run($sformatf("vec%0d", v), vecs[v].beta, vecs[v].burn, vecs[v].ns, vecs[v].cl, -1);
            check($sformatf("vec%0d_c0", v), int'(cnt_a[15:0]),  vecs[v].c0);
            check($sformatf("vec%0d_c1", v), int'(cnt_a[31:16]), vecs[v].c1);
            check($sformatf("vec%0d_c2", v), int'(cnt_a[47:32]), vecs[v].c2);
            check($sformatf("vec%0d_pb", v), int'(pb_f), int'(vecs[v].pb));
        end

        // Start pulsed while busy must not alter the run
        do_run("poke", 3, 1, 10, 6'b11_10_11, 7);
        check("poke_c0", int'(cnt_a[15:0]), 10);
        check("poke_c2", int'(cnt_a[47:32]), 10);

        // AND gate with clamped inputs; Ie = 16 at beta 2 would only bias y to
        // ~56%, so beta 15 is used to push |Ie| to 120 (y agrees ~97% of sweeps)
        do_run("and11", 15, 2, 1000, 6'b00_11_11, -1);
        check_range("and11_y", int'(cnt_a[47:32]), 900, 1000);
        do_run("and01", 15, 2, 1000, 6'b00_11_10, -1);
        check_range("and01_y", int'(cnt_a[47:32]), 0, 100);

        // Zero weights, all free: each bit is a fair coin
        do_run("flat", 1, 0, 4000, 6'b00_00_00, -1);
        for (int k = 0; k < 3; k++)
            check_range($sformatf("flat_bal[%0d]", k), int'(cnt_f[16*k +: 16]), 1800, 2200);

        for (int t = 0; t < 8; t++)
            do_run($sformatf("rnd%0d", t), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 20)), 6'($urandom_range(0, 63)), -1);

        // Reset asserted mid-SAMPLE
        @(negedge clk);
        i0 = 4'd5; burn_sweeps = 16'd0; n_samples = 16'd40; clamp = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("midrun_busy", int'(busy_a), 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", int'(busy_a | busy_f), 0);
        check("rst_async_pbits", int'(pb_a | pb_f), 0);
        check("rst_async_counts", int'((cnt_a | cnt_f) != 48'd0), 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_hold_start_ignored", int'(busy_a | done_a | busy_f | done_f), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pb_ma = '0; pb_mf = '0; lf_ma = SEED_A; lf_mf = 32'd1;
        do_run("after_reset", 6, 1, 12, 6'b00_00_11, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
